// File: rtl/ksa_shuffle_fsm.sv
// RC4 key-scheduling stage: swaps S[i] and S[j] through a single-port synchronous RAM.
// Optional build macro KSA_SKIP_SELF_SWAP_EN skips both writes when i == j.
module ksa_shuffle_fsm #(
  parameter int KEY_LENGTH = 3,
  parameter int MEM_DEPTH  = 256
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    start,
  input  logic [8*KEY_LENGTH-1:0] secret_key,
  input  logic [7:0]              q,
  output logic                    finish,
  output logic                    write_enable,
  output logic [7:0]              address,
  output logic [7:0]              write_data
);

  localparam int              KW     = (KEY_LENGTH > 1) ? $clog2(KEY_LENGTH) : 1;
  localparam logic [7:0]      I_LAST = 8'(MEM_DEPTH - 1);
  localparam logic [KW-1:0]   K_LAST = KW'(KEY_LENGTH - 1);

  typedef enum logic [3:0] {
    IDLE, READ_SI, WAIT_SI, READ_SJ, WAIT_SJ, WRITE_SI, WRITE_SJ, INCR, FINISH
  } state_t;

  state_t                  state_q, state_d;
  logic [7:0]              i_q, i_d, j_q, j_d, si_q, si_d, sj_q, sj_d;
  logic [KW-1:0]           kidx_q, kidx_d;
  logic [8*KEY_LENGTH-1:0] key_q, key_d;
  logic [7:0]              key_byte;

  // Key byte 0 sits in the most significant byte of the latched key.
  always_comb begin
    key_byte = '0;
    for (int k = 0; k < KEY_LENGTH; k++) begin
      if (kidx_q == KW'(k)) key_byte = key_q[8*(KEY_LENGTH-1-k) +: 8];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      i_q     <= '0;
      j_q     <= '0;
      si_q    <= '0;
      sj_q    <= '0;
      kidx_q  <= '0;
      key_q   <= '0;
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      j_q     <= j_d;
      si_q    <= si_d;
      sj_q    <= sj_d;
      kidx_q  <= kidx_d;
      key_q   <= key_d;
    end
  end

  always_comb begin
    state_d = state_q;
    i_d     = i_q;
    j_d     = j_q;
    si_d    = si_q;
    sj_d    = sj_q;
    kidx_d  = kidx_q;
    key_d   = key_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          key_d   = secret_key;
          i_d     = '0;
          j_d     = '0;
          kidx_d  = '0;
          state_d = READ_SI;
        end
      end
      READ_SI: state_d = WAIT_SI;
      WAIT_SI: begin
        si_d    = q;
        j_d     = j_q + q + key_byte;
        state_d = READ_SJ;
      end
      READ_SJ: state_d = WAIT_SJ;
      WAIT_SJ: begin
        sj_d = q;
`ifdef KSA_SKIP_SELF_SWAP_EN
        state_d = (i_q == j_q) ? INCR : WRITE_SI;
`else
        state_d = WRITE_SI;
`endif
      end
      WRITE_SI: state_d = WRITE_SJ;
      WRITE_SJ: state_d = INCR;
      INCR: begin
        if (i_q == I_LAST) begin
          state_d = FINISH;
        end else begin
          i_d     = i_q + 8'd1;
          kidx_d  = (kidx_q == K_LAST) ? '0 : kidx_q + 1'b1;
          state_d = READ_SI;
        end
      end
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs decode registered state only, so reset clears them at once.
  always_comb begin
    finish       = 1'b0;
    write_enable = 1'b0;
    address      = '0;
    write_data   = '0;
    case (state_q)
      READ_SI, WAIT_SI: address = i_q;
      READ_SJ, WAIT_SJ: address = j_q;
      WRITE_SI: begin
        address      = i_q;
        write_data   = sj_q;
        write_enable = 1'b1;
      end
      WRITE_SJ: begin
        address      = j_q;
        write_data   = si_q;
        write_enable = 1'b1;
      end
      FINISH:  finish = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_ksa_shuffle_fsm.sv
// Directed bench for ksa_shuffle_fsm with a synchronous-read RAM and a software KSA model.
module tb_ksa_shuffle_fsm;

`ifdef KSA_SKIP_SELF_SWAP_EN
  localparam int OFS1 = 0, OFS2 = 0, EARLY_WIN = 10, EARLY_EXP = 0;
`else
  localparam int OFS1 = 4, OFS2 = 2, EARLY_WIN = 14, EARLY_EXP = 4;
`endif

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [23:0] secret_key = '0;
  logic [7:0]  q = '0;
  logic        finish, write_enable;
  logic [7:0]  address, write_data;

  logic [7:0]  mem   [256];
  logic [7:0]  exp_s [256];
  logic [15:0] wlog  [$];
  int n_tests = 0, n_fail = 0;
  int fin_cyc, fin_cyc2, fin_cnt, early_we;
  int sc, sc2, f1, f2, bad;

  ksa_shuffle_fsm #(.KEY_LENGTH(3), .MEM_DEPTH(256)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .secret_key(secret_key), .q(q),
    .finish(finish), .write_enable(write_enable), .address(address), .write_data(write_data)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    q <= mem[address];
    if (write_enable) mem[address] = write_data;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic ram_identity();
    for (int k = 0; k < 256; k++) begin
      mem[k]   = 8'(k);
      exp_s[k] = 8'(k);
    end
  endtask

  // Runs the reference KSA in place on exp_s and counts i == j iterations.
  task automatic model(input logic [23:0] key, output int selfs);
    logic [7:0] j, t;
    j = 8'd0;
    selfs = 0;
    for (int i = 0; i < 256; i++) begin
      j = j + exp_s[i] + key[8*(2 - (i % 3)) +: 8];
      if (j == 8'(i)) selfs++;
      t = exp_s[i];
      exp_s[i] = exp_s[j];
      exp_s[j] = t;
    end
  endtask

  function automatic int lat(input int selfs);
`ifdef KSA_SKIP_SELF_SWAP_EN
    return 1792 - 2 * selfs;
`else
    return 1792 + 0 * selfs;
`endif
  endfunction

  function automatic int arr_errs();
    int e = 0;
    for (int k = 0; k < 256; k++) if (mem[k] !== exp_s[k]) e++;
    return e;
  endfunction

  function automatic logic [15:0] wl(input int n);
    return (n < wlog.size()) ? wlog[n] : 16'hxxxx;
  endfunction

  // Cycle 0 is the first READ_SI; outputs are sampled on the falling edge.
  task automatic run_ksa(input logic [23:0] key, input int ncyc, input int xs1, input int xs2,
                         input int hold_to, input int kchg_at, input logic [23:0] key2,
                         input int abort_at);
    wlog.delete();
    fin_cyc = -1; fin_cyc2 = -1; fin_cnt = 0; early_we = 0;
    @(negedge clk);
    secret_key = key;
    start = 1'b1;
    @(posedge clk);
    for (int c = 0; c < ncyc; c++) begin
      @(negedge clk);
      if (c == abort_at) begin
        reset_n = 1'b0;
        start = 1'b0;
        #1;
        check("abort_finish", finish, 0);
        check("abort_we", write_enable, 0);
        check("abort_addr", address, 0);
        check("abort_wdata", write_data, 0);
        return;
      end
      if (write_enable) begin
        wlog.push_back({address, write_data});
        if (c < EARLY_WIN) early_we++;
      end
      if (finish) begin
        fin_cnt++;
        if (fin_cyc < 0) fin_cyc = c;
        else if (fin_cyc2 < 0) fin_cyc2 = c;
      end
      start = (c == xs1) || (c == xs2) || (c < hold_to);
      if (c == kchg_at) secret_key = key2;
    end
    start = 1'b0;
  endtask

  initial begin
    ram_identity();
    repeat (2) @(negedge clk);
    check("rst_finish", finish, 0);
    check("rst_we", write_enable, 0);
    check("rst_addr", address, 0);
    check("rst_wdata", write_data, 0);
    reset_n = 1'b1;

    // Zero key: self-swaps at i=0,1 then first real swap 2<->3
    ram_identity();
    model(24'h000000, sc);
    run_ksa(24'h000000, 1810, -1, -1, 0, -1, '0, -1);
    check("s1_fin_cnt", fin_cnt, 1);
    check("s1_fin_cyc", fin_cyc, lat(sc));
    check("s1_w_i2", wl(OFS1), {8'd2, 8'd3});
    check("s1_w_j3", wl(OFS1 + 1), {8'd3, 8'd2});
    check("s1_early_we", early_we, EARLY_EXP);
    check("s1_array", arr_errs(), 0);

    ram_identity();
    model(24'h000249, sc);
    run_ksa(24'h000249, 1810, -1, -1, 0, -1, '0, -1);
    check("s2_w_i1", wl(OFS2), {8'd1, 8'd3});
    check("s2_w_j3", wl(OFS2 + 1), {8'd3, 8'd1});
    check("s2_fin_cyc", fin_cyc, lat(sc));
    check("s2_array", arr_errs(), 0);

    // Reset in the middle of a run, then a clean rerun
    ram_identity();
    run_ksa(24'h000249, 1810, -1, -1, 0, -1, '0, 1000);
    repeat (3) @(negedge clk);
    check("rst_hold_we", write_enable, 0);
    reset_n = 1'b1;
    bad = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (finish || write_enable || address != 8'd0) bad++;
    end
    check("rst_idle_quiet", bad, 0);
    ram_identity();
    model(24'h000249, sc);
    run_ksa(24'h000249, 1810, -1, -1, 0, -1, '0, -1);
    check("rerun_fin_cyc", fin_cyc, lat(sc));
    check("rerun_array", arr_errs(), 0);

    // Extra start pulses mid-run are ignored
    ram_identity();
    model(24'h000249, sc);
    run_ksa(24'h000249, 1810, 10, 900, 0, -1, '0, -1);
    check("xs_fin_cnt", fin_cnt, 1);
    check("xs_fin_cyc", fin_cyc, lat(sc));
    check("xs_array", arr_errs(), 0);

    // start held through FINISH: back-to-back second run on the shuffled array
    ram_identity();
    model(24'h000249, sc);
    f1 = lat(sc);
    model(24'h000249, sc2);
    f2 = lat(sc2);
    run_ksa(24'h000249, 3600, -1, -1, f1 + 2, -1, '0, -1);
    check("hold_fin_cnt", fin_cnt, 2);
    check("hold_fin1", fin_cyc, f1);
    check("hold_fin2", fin_cyc2, f1 + 2 + f2);
    check("hold_array", arr_errs(), 0);

    // Key changes after acceptance have no effect
    ram_identity();
    model(24'h000249, sc);
    run_ksa(24'h000249, 1810, -1, -1, 0, 5, 24'hFFFFFF, -1);
    check("kchg_fin_cyc", fin_cyc, lat(sc));
    check("kchg_array", arr_errs(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ksa_shuffle_fsm.md
Name: ksa_shuffle_fsm

Overview:
- RC4 key-scheduling stage: permutes the 256-byte S-array in on-chip RAM using the secret key. For i = 0..255: j = j + S[i] + key[i mod KEY_LENGTH]; swap S[i], S[j].
- Sits directly downstream of the init (S[i]=i) stage.
- Started by the top-level control FSM via a one-cycle start pulse. Returns finish to that FSM.
- Its write_enable/address/write_data are muxed onto the single-port S RAM by the control FSM; read data q comes back from that RAM.

Parameters:
- KEY_LENGTH, 3, number of key bytes; secret_key width is 8*KEY_LENGTH.
- MEM_DEPTH, 256, number of S entries; i runs 0..MEM_DEPTH-1. Must equal 2^8; 8-bit address.

Ports:
- clk  input  1  system clock, all logic on rising edge
- reset_n  input  1  asynchronous, active-low reset
- start  input  1  start request, sampled only in IDLE
- secret_key  input  8*KEY_LENGTH  key; byte 0 = secret_key[8*KEY_LENGTH-1 -: 8] (MSB byte first)
- q  input  8  S RAM read data
- finish  output  1  one-cycle done pulse
- write_enable  output  1  S RAM write strobe
- address  output  8  S RAM address
- write_data  output  8  S RAM write data

Behaviour:
- Reset (reset_n low, any time, including mid-run):
  - State goes to IDLE immediately.
  - i, j, key index, si and sj all cleared to 0.
  - finish, write_enable, address and write_data all 0.
  - No partial write completes after reset asserts.
- RAM timing: synchronous read. q is valid in the second cycle the address is held (address driven in cycle N and N+1; q sampled at the end of N+1).
- Outputs are driven only from registered state/i/j/si/sj. There is no combinational path from start or q to any output.
- States and per-state outputs (write_enable = 0 unless noted):
  - IDLE: if start, latch secret_key, i=0, j=0, kidx=0 -> READ_SI.
  - READ_SI: address=i -> WAIT_SI.
  - WAIT_SI: address=i; si <= q; j <= j + q + key[kidx] -> READ_SJ.
  - READ_SJ: address=j (new j) -> WAIT_SJ.
  - WAIT_SJ: address=j; sj <= q -> WRITE_SI.
  - WRITE_SI: address=i, write_data=sj, write_enable=1 -> WRITE_SJ.
  - WRITE_SJ: address=j, write_data=si, write_enable=1 -> INCR.
  - INCR: if i==MEM_DEPTH-1 -> FINISH; else i++, kidx = (kidx==KEY_LENGTH-1) ? 0 : kidx+1 -> READ_SI.
  - FINISH: finish=1 for exactly one cycle -> IDLE.
- Arithmetic and counters:
  - j is 8-bit; the sum wraps mod 256.
  - kidx is a wrap counter, no divider.
  - i does not wrap past 255.
- Latency: 7 cycles per iteration. FINISH occurs 256*7 = 1792 cycles after the first READ_SI.
- Self-swap (i==j): both writes still occur (same value written twice; harmless) unless the optional feature is enabled.
- start while not IDLE: ignored, no restart.
- start high in the cycle after FINISH (i.e. in IDLE): a new run begins.
- secret_key changes after acceptance: no effect until the next start.

Optional Feature:
- Macro: KSA_SKIP_SELF_SWAP_EN.
- Defined: WAIT_SJ goes directly to INCR when i==j. WRITE_SI and WRITE_SJ are skipped, with no write_enable pulses for that iteration. Total latency becomes 1792 - 2*(number of self-swaps).
- Undefined: fixed 1792-cycle run; writes always issued.

Test Plan:
1. RAM preloaded S[k]=k, secret_key=24'h000000, start pulse:
   - i=0: j=0; i=1: j=1 (self-swaps).
   - i=2: j=3; write addr 2 data 3, then addr 3 data 2.
   - finish pulses once, 1792 cycles after the first READ_SI.
   - Final RAM matches the software RC4 KSA model.
2. Identity RAM, secret_key=24'h000249:
   - i=0: j=0.
   - i=1: j=0+1+0x02=3; writes addr 1 data 3, addr 3 data 1.
   - Full final array matches the model.
3. With KSA_SKIP_SELF_SWAP_EN, key 24'h000000:
   - No write_enable during i=0 and i=1.
   - finish cycle count = 1792 - 2*(self-swap count from model).
   - Final array identical to scenario 1.
4. Reset mid-run: drop reset_n at cycle 1000 of the run.
   - All outputs 0 in the same cycle.
   - After release, FSM stays IDLE with finish=0 until a new start.
   - Rerun from a fresh identity array matches the model.
5. Extra start pulses at cycles 10 and 900 of the run:
   - No restart; exactly one finish pulse at cycle 1792.
   - start held high through FINISH: second run begins in the cycle after FINISH.
6. Change secret_key from 24'h000249 to 24'hFFFFFF at cycle 5 of the run: final array equals the 24'h000249 result.
